// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table exerciser.
package gate_check_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } gc_state_t;

  // Expected truth tables: bit i is the gate output for input vector i.
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;
  localparam logic [1:0] TT_NOT1  = 2'b01;

  // Settle counter width, enough for settle times 0..15.
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Settle down-counter: loaded at the start of each vector, counts down while
// enabled, and reports expiry once the vector has had SETTLE wait cycles.
// A zero settle time reports expiry permanently.
module settle_timer
  import gate_check_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [SETTLE_W-1:0] LOAD_VAL =
    (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] r_count;

  // Count down from SETTLE-1 to zero; a load restarts the wait.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order between blocks.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (SETTLE == 0) || (r_count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Truth-table exerciser: on start, sweeps every input vector onto a gate,
// waits SETTLE cycles per vector, samples the gate output, and reports the
// captured table, a per-vector mismatch mask and an overall pass flag.
// Optional feature macro: GATE_CHECK_EARLY_ABORT_EN -- a mismatching sample
// ends the sweep immediately instead of sweeping all vectors.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN     = 2,
  parameter int                    SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = TT_XNOR2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(2**N_IN)-1:0]   captured,
  output logic [(2**N_IN)-1:0]   fail_mask
);

  localparam int                N_VEC    = 2**N_IN;
  localparam int                VEC_W    = N_IN + 1;
  localparam logic [VEC_W-1:0]  LAST_VEC = VEC_W'(N_VEC - 1);

  gc_state_t          r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [N_IN-1:0]    r_dut_in;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [N_VEC-1:0]   r_captured;
  logic [N_VEC-1:0]   r_fail_mask;

  logic [N_IN-1:0]    w_idx;
  logic               w_mismatch;
  logic               w_last;
  logic               w_finish;
  logic [N_VEC-1:0]   w_fail_next;
  logic               w_timer_load;
  logic               w_timer_en;
  logic               w_expired;

  assign w_idx       = r_vec[N_IN-1:0];
  assign w_mismatch  = dut_out ^ EXPECTED[w_idx];
  assign w_last      = (r_vec == LAST_VEC);
  assign w_fail_next = r_fail_mask | ({{(N_VEC-1){1'b0}}, w_mismatch} << w_idx);

  // Decide whether this sample ends the sweep and drive the settle timer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_finish     = w_last;
`ifdef GATE_CHECK_EARLY_ABORT_EN
    w_finish     = w_last || w_mismatch;
`endif
    w_timer_load = 1'b0;
    w_timer_en   = (r_state == ST_SETTLE);
    if (r_state == ST_IDLE && start) begin
      w_timer_load = 1'b1;
    end else if (r_state == ST_SAMPLE && !w_finish) begin
      w_timer_load = 1'b1;
    end
  end

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_timer_load),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  // Sweep sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: captured/fail_mask are plain flop vectors, not a RAM, so they
      // are reset along with the rest of the state.
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_dut_in    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_captured  <= '0;
      r_fail_mask <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_captured  <= '0;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
            r_vec       <= '0;
            r_dut_in    <= '0;
            r_busy      <= 1'b1;
            r_state     <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_expired) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_captured[w_idx] <= dut_out;
          r_fail_mask       <= w_fail_next;
          if (w_finish) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= ~|w_fail_next;
            r_state <= ST_DONE;
          end else begin
            r_vec    <= r_vec + 1'b1;
            r_dut_in <= w_idx + 1'b1;
            r_state  <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_DONE: begin
          r_dut_in <= '0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign captured  = r_captured;
  assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three instances (XNOR2/settle 1, AND2/settle 3,
// inverter/settle 0) driven by a bench-side gate table, checked against a
// truth-table reference model.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] din;
    logic [3:0] cap;
    logic [3:0] fm;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st0, st1, st2;
  logic [3:0] tbl [3];
  logic [1:0] din0, din1;
  logic       din2;
  logic       dout0, dout1, dout2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [3:0] cap0, cap1, fm0, fm1;
  logic [1:0] cap2, fm2;

  int         nin_c [3] = '{2, 2, 1};
  int         stl_c [3] = '{1, 3, 0};
  logic [3:0] exp_c [3] = '{TT_XNOR2, TT_AND2, 4'(TT_NOT1)};

  int checks = 0;
  int errors = 0;

  assign dout0 = tbl[0][din0];
  assign dout1 = tbl[1][din1];
  assign dout2 = tbl[2][{1'b0, din2}];

  gate_truth_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(TT_XNOR2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .dut_in(din0), .dut_out(dout0),
    .busy(busy0), .done(done0), .pass(pass0), .captured(cap0), .fail_mask(fm0));

  gate_truth_checker #(.N_IN(2), .SETTLE(3), .EXPECTED(TT_AND2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .dut_in(din1), .dut_out(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .captured(cap1), .fail_mask(fm1));

  gate_truth_checker #(.N_IN(1), .SETTLE(0), .EXPECTED(TT_NOT1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .dut_in(din2), .dut_out(dout2),
    .busy(busy2), .done(done2), .pass(pass2), .captured(cap2), .fail_mask(fm2));

  function automatic obs_t obs(input int k);
    obs_t o;
    case (k)
      0:       o = '{busy0, done0, pass0, din0, cap0, fm0};
      1:       o = '{busy1, done1, pass1, din1, cap1, fm1};
      default: o = '{busy2, done2, pass2, {1'b0, din2}, {2'b00, cap2}, {2'b00, fm2}};
    endcase
    return o;
  endfunction

  task automatic set_start(input int k, input logic v);
    case (k)
      0:       st0 = v;
      1:       st1 = v;
      default: st2 = v;
    endcase
  endtask

  // Reference: a sweep applies vectors 0..N_VEC-1 (or stops at the first
  // mismatch with early abort); each takes SETTLE+1 cycles, DONE follows.
  task automatic model(input int k, input logic [3:0] t, output logic [3:0] cap,
                       output logic [3:0] fm, output logic ps, output int dc);
    int nv;
    int last;
    nv   = 1 << nin_c[k];
    last = nv - 1;
    cap  = '0;
    fm   = '0;
`ifdef GATE_CHECK_EARLY_ABORT_EN
    for (int i = nv - 1; i >= 0; i--)
      if (t[i] !== exp_c[k][i]) last = i;
`endif
    for (int i = 0; i <= last; i++) begin
      cap[i] = t[i];
      fm[i]  = t[i] ^ exp_c[k][i];
    end
    ps = (fm == 4'b0000);
    dc = (last + 1) * (stl_c[k] + 1) + 1;
  endtask

  // One start pulse, then follow the sweep cycle by cycle.
  task automatic run_and_check(input string name, input int k);
    logic [3:0] ecap, efm;
    logic       eps;
    int         edc, dc, ev;
    obs_t       o;
    model(k, tbl[k], ecap, efm, eps, edc);
    @(negedge clk);
    set_start(k, 1'b1);
    dc = 0;
    for (int c = 1; c <= 200 && dc == 0; c++) begin
      @(negedge clk);
      if (c == 1) set_start(k, 1'b0);
      o = obs(k);
      if (o.busy) begin
        ev = (c - 1) / (stl_c[k] + 1);
        checks++;
        if (o.din !== 2'(ev)) begin
          errors++;
          $display("FAIL %s dut_in cycle %0d: got %0d want %0d", name, c, o.din, ev);
        end
      end
      if (o.done) begin
        dc = c;
        checks++;
        if (dc != edc || o.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_timing: cycle %0d busy %b want cycle %0d busy 0",
                   name, dc, o.busy, edc);
        end
        checks++;
        if (o.cap !== ecap || o.fm !== efm || o.pass !== eps) begin
          errors++;
          $display("FAIL %s result: cap %b fm %b pass %b want cap %b fm %b pass %b",
                   name, o.cap, o.fm, o.pass, ecap, efm, eps);
        end
      end
    end
    if (dc == 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 200 cycles, want done at %0d", name, edc);
    end
    @(negedge clk);
    o = obs(k);
    checks++;
    if (o.busy !== 1'b0 || o.done !== 1'b0 || o.din !== 2'b00 || o.pass !== eps) begin
      errors++;
      $display("FAIL %s idle_after: busy %b done %b din %0d pass %b want 0 0 0 %b",
               name, o.busy, o.done, o.din, o.pass, eps);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    tbl[0] = TT_XNOR2; tbl[1] = TT_AND2; tbl[2] = 4'(TT_NOT1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_values u%0d: got %h want 0", k, o);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    tbl[0] = TT_XNOR2;  run_and_check("xnor_correct", 0);
    tbl[0] = TT_XOR2;   run_and_check("xor_connected", 0);
    tbl[0] = 4'b1111;   run_and_check("stuck_at_1", 0);
    tbl[1] = TT_AND2;   run_and_check("and_settle3", 1);
    tbl[1] = TT_OR2;    run_and_check("or_on_and", 1);
  endtask

  task automatic test_inverter();
    tbl[2] = 4'b0001;   run_and_check("inverter", 2);
    tbl[2] = 4'b0000;   run_and_check("inverter_stuck0", 2);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 16; n++) begin
      k = $urandom_range(0, 2);
      tbl[k] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tbl[k] = exp_c[k];
      if (k == 2) tbl[k][3:2] = 2'b00;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_and_check("random", k);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ecap, efm;
    logic       eps;
    int         edc, per, exp_n, nd, overlap, drop_at;
    obs_t       o;
    tbl[0] = TT_XNOR2;
    model(0, tbl[0], ecap, efm, eps, edc);
    per   = edc + 1;
    exp_n = 19 / per + 1;
    nd = 0; overlap = 0;
    @(negedge clk);
    st0 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 20) st0 = 1'b0;
      o = obs(0);
      if (o.busy && o.done) overlap++;
      if (o.done) begin
        checks++;
        if (c != edc + nd * per || o.pass !== 1'b1) begin
          errors++;
          $display("FAIL held_start done %0d: cycle %0d pass %b want cycle %0d pass 1",
                   nd, c, o.pass, edc + nd * per);
        end
        nd++;
      end
    end
    checks++;
    if (nd != exp_n || overlap != 0) begin
      errors++;
      $display("FAIL held_start count: dones %0d overlaps %0d want %0d and 0",
               nd, overlap, exp_n);
    end
    // Start pulses while busy and during DONE must not spawn another sweep.
    nd = 0; drop_at = -1;
    @(negedge clk);
    st0 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 || c == 5 || c == drop_at) st0 = 1'b0;
      if (c == 4) st0 = 1'b1;
      o = obs(0);
      if (o.busy && o.done) overlap++;
      if (o.done) begin
        nd++;
        st0 = 1'b1;
        drop_at = c + 1;
      end
    end
    checks++;
    if (nd != 1 || overlap != 0) begin
      errors++;
      $display("FAIL ignored_start: dones %0d overlaps %0d want 1 and 0", nd, overlap);
    end
  endtask

  task automatic test_reset_mid_sweep();
    obs_t o;
    int   hit;
    tbl[0] = TT_XNOR2;
    run_and_check("pre_reset", 0);
    @(negedge clk);
    st0 = 1'b1;
    hit = 0;
    for (int c = 1; c <= 20 && hit == 0; c++) begin
      @(negedge clk);
      st0 = 1'b0;
      o = obs(0);
      if (o.busy && o.din == 2'd2) hit = 1;
    end
    checks++;
    if (hit == 0) begin
      errors++;
      $display("FAIL reset_mid reach_vec2: vector 2 never seen, want it within 20 cycles");
    end
    rst_n = 1'b0;
    @(negedge clk);
    o = obs(0);
    rst_n = 1'b1;
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %h want 0", o);
    end
    repeat (2) @(negedge clk);
    o = obs(0);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_mid stays_idle: got %h want 0", o);
    end
    run_and_check("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_inverter();
    test_back_to_back();
    test_reset_mid_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
